seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, program-memory address width (32 words).
REQ-002 Parameter RST_VEC, default 0, PC value loaded at reset and on clear.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; continuous execution while high.
REQ-006 step  input  1  single-cycle pulse; executes exactly one instruction from IDLE.
REQ-007 halt_req  input  1  pulse or level; stop after the current instruction.
REQ-008 clear  input  1  synchronous; leaves HALT, PC <= RST_VEC.
REQ-009 jmp_en  input  1  decoded jump, sampled in EXEC only.
REQ-010 jmp_addr  input  ADDR_W  jump/call target.
REQ-011 skip_en  input  1  decoded skip-if-carry, sampled in EXEC only.
REQ-012 cy  input  1  carry flag from datapath.
REQ-013 addr  output  ADDR_W  program-memory address (PC), registered.
REQ-014 exec_en  output  1  high only in EXEC; downstream qualifies Reg_CE, CY_CE, A_CE with it.
REQ-015 state  output  2  encoding IDLE=00, FETCH=01, EXEC=10, HALT=11.
REQ-016 halted  output  1  high in HALT.
REQ-017 pc_wrap  output  1  sticky; set when PC increments from 2^ADDR_W-1 to 0.

Function
REQ-018 Each instruction takes exactly 2 cycles: FETCH (addr stable, exec_en=0) then EXEC (exec_en=1).
REQ-019 IDLE -> FETCH when run=1 or step=1; otherwise stay in IDLE.
REQ-020 FETCH -> EXEC unconditionally.
REQ-021 EXEC -> HALT if halt_req=1; else FETCH if run=1 and step-mode not active; else IDLE.
REQ-022 Instruction started by step with run=0 returns to IDLE after its EXEC; step ignored outside IDLE.
REQ-023 Next PC is computed and loaded only at end of EXEC; priority: jmp_en -> jmp_addr; skip_en&cy -> PC+2; else PC+1.
REQ-024 jmp_en and skip_en both high: jump wins, skip ignored.
REQ-025 PC arithmetic is modulo 2^ADDR_W; PC+2 from 2^ADDR_W-1 gives 1, from 2^ADDR_W-2 gives 0; either wrap sets pc_wrap; jump never sets it.
REQ-026 run dropped during FETCH or EXEC: current instruction completes, then IDLE; never aborts mid-instruction.
REQ-027 HALT held regardless of run/step; clear in HALT -> IDLE, PC <= RST_VEC, pc_wrap <= 0.
REQ-028 clear in IDLE: PC <= RST_VEC, pc_wrap <= 0; clear in FETCH/EXEC ignored.
REQ-029 jmp_en, skip_en, cy ignored outside EXEC.

Reset
REQ-030 nReset low: state=IDLE, addr=RST_VEC, exec_en=0, halted=0, pc_wrap=0, immediately, no clock required.
REQ-031 Reset mid-instruction discards it; first FETCH after release needs run or step sampled high while nReset=1.

Configuration
REQ-032 Macro SEQ_CALL_STACK_EN defined: adds inputs call_en, ret_en (1 bit) and a single ADDR_W-bit link register, reset to RST_VEC.
REQ-033 With macro, in EXEC: ret_en -> PC <= link; call_en -> link <= PC+1, PC <= jmp_addr; priority ret > call > jmp > skip > increment.
REQ-034 Macro undefined: call_en, ret_en and link absent; behaviour exactly REQ-018..031.

Verification
REQ-035 Reset, run=1 for 8 cycles, no jumps -> addr 0,0,1,1,2,2,3,3; exec_en 0,1 alternating.
REQ-036 PC=5, EXEC with skip_en=1, cy=1 -> next FETCH addr=7; cy=0 -> addr=6; jmp_en=1 with jmp_addr=20 and skip -> addr=20.
REQ-037 Run from PC=31 -> next addr=0, pc_wrap=1 and held until clear; skip at PC=30 with cy=1 -> addr=0, pc_wrap=1.
REQ-038 run=0, step pulse at PC=3 -> one FETCH/EXEC, addr=4, state=IDLE; second step in FETCH ignored.
REQ-039 halt_req during EXEC at PC=9 -> state=HALT, halted=1, addr=10; run toggling no effect; clear -> IDLE, addr=0.
REQ-040 SEQ_CALL_STACK_EN: call at PC=4 to 12 -> addr=12, link=5; ret at 12 -> addr=5; nReset low in EXEC -> IDLE, addr=0 asynchronously.

Source files
------------

// File: rtl/seq_ctrl.sv
// Two-cycle (FETCH/EXEC) program sequencer with PC, jump, skip-if-carry and sticky wrap flag.
// Optional single-level call/return link register enabled by defining SEQ_CALL_STACK_EN.
module seq_ctrl #(
    parameter int          ADDR_W  = 5,
    parameter int unsigned RST_VEC = 0
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    input  logic              clear,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              skip_en,
    input  logic              cy,
`ifdef SEQ_CALL_STACK_EN
    input  logic              call_en,
    input  logic              ret_en,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic              exec_en,
    output logic [1:0]        state,
    output logic              halted,
    output logic              pc_wrap
);

    localparam logic [ADDR_W-1:0] RST_PC = RST_VEC[ADDR_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              wrap_q, wrap_d;
    logic              step_mode_q, step_mode_d;
    logic [ADDR_W:0]   pc_inc;
`ifdef SEQ_CALL_STACK_EN
    logic [ADDR_W-1:0] link_q, link_d;
`endif

    // Extra MSB of pc_inc is the carry out of the PC, i.e. the wrap event.
    assign pc_inc = {1'b0, pc_q} + ((skip_en && cy) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wrap_d      = wrap_q;
        step_mode_d = step_mode_q;
`ifdef SEQ_CALL_STACK_EN
        link_d      = link_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    pc_d   = RST_PC;
                    wrap_d = 1'b0;
                end
                if (run || step) begin
                    state_d     = S_FETCH;
                    step_mode_d = !run;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
`ifdef SEQ_CALL_STACK_EN
                if (ret_en) begin
                    pc_d = link_q;
                end else if (call_en) begin
                    link_d = pc_q + ADDR_W'(1);
                    pc_d   = jmp_addr;
                end else
`endif
                if (jmp_en) begin
                    pc_d = jmp_addr;
                end else begin
                    pc_d = pc_inc[ADDR_W-1:0];
                    if (pc_inc[ADDR_W]) wrap_d = 1'b1;
                end
                if (halt_req)                  state_d = S_HALT;
                else if (run && !step_mode_q)  state_d = S_FETCH;
                else                           state_d = S_IDLE;
            end
            default: begin
                if (clear) begin
                    state_d = S_IDLE;
                    pc_d    = RST_PC;
                    wrap_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            pc_q        <= RST_PC;
            wrap_q      <= 1'b0;
            step_mode_q <= 1'b0;
`ifdef SEQ_CALL_STACK_EN
            link_q      <= RST_PC;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wrap_q      <= wrap_d;
            step_mode_q <= step_mode_d;
`ifdef SEQ_CALL_STACK_EN
            link_q      <= link_d;
`endif
        end
    end

    assign addr    = pc_q;
    assign exec_en = (state_q == S_EXEC);
    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign pc_wrap = wrap_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: instruction-level reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_seq_ctrl;

    localparam int AW    = 5;
    localparam int RV    = 0;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          nReset = 1'b1;
    logic          run = 1'b0, step = 1'b0, halt_req = 1'b0, clear = 1'b0;
    logic          jmp_en = 1'b0, skip_en = 1'b0, cy = 1'b0;
    logic [AW-1:0] jmp_addr = '0;
`ifdef SEQ_CALL_STACK_EN
    logic          call_en = 1'b0, ret_en = 1'b0;
`endif
    logic [AW-1:0] addr;
    logic          exec_en, halted, pc_wrap;
    logic [1:0]    state;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    seq_ctrl #(.ADDR_W(AW), .RST_VEC(RV)) dut (
        .clk(clk), .nReset(nReset), .run(run), .step(step), .halt_req(halt_req),
        .clear(clear), .jmp_en(jmp_en), .jmp_addr(jmp_addr), .skip_en(skip_en), .cy(cy),
`ifdef SEQ_CALL_STACK_EN
        .call_en(call_en), .ret_en(ret_en),
`endif
        .addr(addr), .exec_en(exec_en), .state(state), .halted(halted), .pc_wrap(pc_wrap)
    );

    // ---------------- reference model ----------------
    // Phase numbers are the architectural state codes: 0 idle, 1 fetch, 2 exec, 3 halt.
    int m_ph, m_pc, m_link;
    bit m_wrap, m_stepm;

    // Unreduced next PC; any value >= DEPTH means the counter wrapped.
    function automatic int raw_next();
`ifdef SEQ_CALL_STACK_EN
        if (ret_en)  return m_link;
        if (call_en) return int'(jmp_addr);
`endif
        if (jmp_en)  return int'(jmp_addr);
        return m_pc + ((skip_en && cy) ? 2 : 1);
    endfunction

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            m_ph <= 0; m_pc <= RV; m_wrap <= 1'b0; m_stepm <= 1'b0; m_link <= RV;
        end else begin
            case (m_ph)
                0: begin
                    if (clear) begin m_pc <= RV; m_wrap <= 1'b0; end
                    if (run || step) begin m_ph <= 1; m_stepm <= !run; end
                end
                1: m_ph <= 2;
                2: begin
                    m_pc <= raw_next() % DEPTH;
                    if (raw_next() >= DEPTH) m_wrap <= 1'b1;
`ifdef SEQ_CALL_STACK_EN
                    if (!ret_en && call_en) m_link <= (m_pc + 1) % DEPTH;
`endif
                    m_ph <= halt_req ? 3 : ((run && !m_stepm) ? 1 : 0);
                end
                default: if (clear) begin m_ph <= 0; m_pc <= RV; m_wrap <= 1'b0; end
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_state",   32'(state),   32'(m_ph));
            check("model_addr",    32'(addr),    32'(m_pc));
            check("model_exec_en", 32'(exec_en), 32'(m_ph == 2));
            check("model_halted",  32'(halted),  32'(m_ph == 3));
            check("model_pc_wrap", 32'(pc_wrap), 32'(m_wrap));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // From IDLE: single-step one instruction with the given decode inputs held through EXEC.
    task automatic step_instr(input bit j, input int ja, input bit sk, input bit c, input bit h);
        step = 1'b1;
        tick();
        step = 1'b0; jmp_en = j; jmp_addr = AW'(ja); skip_en = sk; cy = c; halt_req = h;
        tick(2);
        jmp_en = 1'b0; skip_en = 1'b0; cy = 1'b0; halt_req = 1'b0;
    endtask

    task automatic goto_pc(input int p);
        step_instr(1'b1, p, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int exp_a[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    initial begin
        #1 nReset = 1'b0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_addr", 32'(addr), RV);
        check("rst_exec_en", 32'(exec_en), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_wrap", 32'(pc_wrap), 0);
        cmp_en = 1'b1;
        @(negedge clk);
        nReset = 1'b1;
        tick();
        check("idle_no_run", 32'(state), 0);

        // continuous run from reset
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("run_addr", 32'(addr), 32'(exp_a[i]));
            check("run_exec_en", 32'(exec_en), 32'(i % 2));
        end
        run = 1'b0;
        tick();
        check("run_stop_state", 32'(state), 0);
        check("run_stop_addr", 32'(addr), 4);

        // skip / jump priority
        goto_pc(5);
        step_instr(1'b0, 0, 1'b1, 1'b1, 1'b0);
        check("skip_cy1", 32'(addr), 7);
        goto_pc(5);
        step_instr(1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("skip_cy0", 32'(addr), 6);
        goto_pc(5);
        step_instr(1'b1, 20, 1'b1, 1'b1, 1'b0);
        check("jmp_over_skip", 32'(addr), 20);

        // wrap behaviour
        goto_pc(31);
        run = 1'b1;
        tick();
        check("wrap_fetch_addr", 32'(addr), 31);
        run = 1'b0;
        tick(2);
        check("wrap_addr", 32'(addr), 0);
        check("wrap_flag", 32'(pc_wrap), 1);
        goto_pc(30);
        check("wrap_sticky", 32'(pc_wrap), 1);
        clear_pulse();
        check("clear_addr", 32'(addr), 0);
        check("clear_wrap", 32'(pc_wrap), 0);
        goto_pc(30);
        check("jump_no_wrap", 32'(pc_wrap), 0);
        step_instr(1'b0, 0, 1'b1, 1'b1, 1'b0);
        check("skip30_addr", 32'(addr), 0);
        check("skip30_wrap", 32'(pc_wrap), 1);
        clear_pulse();
        goto_pc(31);
        step_instr(1'b0, 0, 1'b1, 1'b1, 1'b0);
        check("skip31_addr", 32'(addr), 1);
        check("skip31_wrap", 32'(pc_wrap), 1);
        clear_pulse();

        // single step with an extra step during FETCH
        goto_pc(3);
        step = 1'b1;
        tick();
        check("step_fetch", 32'(state), 1);
        tick();
        step = 1'b0;
        tick();
        check("step_addr", 32'(addr), 4);
        check("step_idle", 32'(state), 0);
        tick();
        check("step_still_idle", 32'(state), 0);

        // halt, run/step ignored in HALT, clear
        goto_pc(9);
        step_instr(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("halt_state", 32'(state), 3);
        check("halt_flag", 32'(halted), 1);
        check("halt_addr", 32'(addr), 10);
        run = 1'b1;
        tick(2);
        step = 1'b1;
        tick();
        run = 1'b0; step = 1'b0;
        tick();
        check("halt_held", 32'(state), 3);
        check("halt_held_addr", 32'(addr), 10);
        clear_pulse();
        check("halt_clear_state", 32'(state), 0);
        check("halt_clear_addr", 32'(addr), 0);

        // clear during FETCH/EXEC ignored; decode inputs ignored in IDLE
        goto_pc(7);
        step = 1'b1;
        tick();
        step = 1'b0; clear = 1'b1;
        tick(2);
        clear = 1'b0;
        check("clear_midinstr_addr", 32'(addr), 8);
        jmp_en = 1'b1; jmp_addr = AW'(17); skip_en = 1'b1; cy = 1'b1;
        tick(2);
        jmp_en = 1'b0; skip_en = 1'b0; cy = 1'b0;
        check("idle_decode_ignored", 32'(addr), 8);

        // run held continuously then dropped in FETCH
        run = 1'b1;
        tick(3);
        run = 1'b0;
        tick(2);
        check("run_drop_fetch_addr", 32'(addr), 10);
        check("run_drop_fetch_state", 32'(state), 0);

`ifdef SEQ_CALL_STACK_EN
        goto_pc(4);
        call_en = 1'b1;
        step_instr(1'b0, 12, 1'b0, 1'b0, 1'b0);
        call_en = 1'b0;
        check("call_addr", 32'(addr), 12);
        ret_en = 1'b1;
        step_instr(1'b1, 20, 1'b0, 1'b0, 1'b0);
        ret_en = 1'b0;
        check("ret_addr", 32'(addr), 5);
`endif

        // asynchronous reset in EXEC
        run = 1'b1;
        tick(2);
        check("pre_reset_exec", 32'(exec_en), 1);
        #2 nReset = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 0);
        check("async_rst_addr", 32'(addr), RV);
        check("async_rst_exec_en", 32'(exec_en), 0);
        run = 1'b0;
        @(negedge clk);
        nReset = 1'b1;
        tick();
        check("post_reset_idle", 32'(state), 0);
        run = 1'b1;
        tick();
        check("post_reset_fetch", 32'(state), 1);
        run = 1'b0;
        tick(2);
        check("post_reset_addr", 32'(addr), 1);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
